// File: rtl/chirp_sweep_ctrl.sv
// rtl/chirp_sweep_ctrl.sv - LFM chirp sweep sequencer driving the phase accumulator tuning word
module chirp_sweep_ctrl #(
    parameter int N     = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [N-1:0]     f_start_i,
    input  logic [N-1:0]     f_step_i,
    input  logic [CNT_W-1:0] n_steps_i,
    input  logic [CNT_W-1:0] dwell_i,
    input  logic             triangle_i,
    input  logic             continuous_i,
    output logic [N-1:0]     ftw_o,
    output logic             acc_clr_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] step_idx_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [N-1:0]     ftw_q, ftw_d;
    logic [CNT_W-1:0] step_q, step_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;
    logic             acc_clr_q, acc_clr_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    // Configuration captured at start so host writes mid-sweep cannot disturb the chirp
    logic [N-1:0]     fs_q, fs_d;
    logic [N-1:0]     fst_q, fst_d;
    logic [CNT_W-1:0] nst_q, nst_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             tri_q, tri_d;
    logic             cont_q, cont_d;

    logic             dwell_end;
    logic             period_end;

    assign dwell_end = (dcnt_q == dwell_q);

    // Next-state and output computation; abort overrides all sweep activity
    always_comb begin
        state_d    = state_q;
        ftw_d      = ftw_q;
        step_d     = step_q;
        dcnt_d     = dcnt_q;
        acc_clr_d  = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        fs_d       = fs_q;
        fst_d      = fst_q;
        nst_d      = nst_q;
        dwell_d    = dwell_q;
        tri_d      = tri_q;
        cont_d     = cont_q;
        period_end = 1'b0;

        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            ftw_d   = '0;
            step_d  = '0;
            dcnt_d  = '0;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        fs_d      = f_start_i;
                        fst_d     = f_step_i;
                        nst_d     = n_steps_i;
                        dwell_d   = dwell_i;
                        tri_d     = triangle_i;
                        cont_d    = continuous_i;
                        state_d   = S_UP;
                        ftw_d     = f_start_i;
                        step_d    = '0;
                        dcnt_d    = '0;
                        acc_clr_d = 1'b1;
                        busy_d    = 1'b1;
                    end
                end
                S_UP: begin
                    if (!dwell_end) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end else if (step_q < nst_q) begin
                        ftw_d  = ftw_q + fst_q;
                        step_d = step_q + 1'b1;
                        dcnt_d = '0;
                    end else if (tri_q && nst_q != '0) begin
                        // Peak was already dwelt on in UP, so DOWN starts one step below it
                        state_d = S_DOWN;
                        ftw_d   = ftw_q - fst_q;
                        step_d  = nst_q - 1'b1;
                        dcnt_d  = '0;
                    end else begin
                        period_end = 1'b1;
                    end
                end
                S_DOWN: begin
                    if (!dwell_end) begin
                        dcnt_d = dcnt_q + 1'b1;
                    end else if (step_q != '0) begin
                        ftw_d  = ftw_q - fst_q;
                        step_d = step_q - 1'b1;
                        dcnt_d = '0;
                    end else begin
                        period_end = 1'b1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ftw_d   = '0;
                    step_d  = '0;
                    dcnt_d  = '0;
                    busy_d  = 1'b0;
                end
            endcase

            // Continuous mode restarts without acc_clr so the output phase stays continuous
            if (period_end) begin
                done_d = 1'b1;
                dcnt_d = '0;
                step_d = '0;
                if (cont_q) begin
                    state_d = S_UP;
                    ftw_d   = fs_q;
                end else begin
                    state_d = S_IDLE;
                    ftw_d   = '0;
                    busy_d  = 1'b0;
                end
            end
        end
    end

    // State, output and shadow configuration registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_IDLE;
            ftw_q     <= '0;
            step_q    <= '0;
            dcnt_q    <= '0;
            acc_clr_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            fs_q      <= '0;
            fst_q     <= '0;
            nst_q     <= '0;
            dwell_q   <= '0;
            tri_q     <= 1'b0;
            cont_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ftw_q     <= ftw_d;
            step_q    <= step_d;
            dcnt_q    <= dcnt_d;
            acc_clr_q <= acc_clr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            fs_q      <= fs_d;
            fst_q     <= fst_d;
            nst_q     <= nst_d;
            dwell_q   <= dwell_d;
            tri_q     <= tri_d;
            cont_q    <= cont_d;
        end
    end

    assign ftw_o      = ftw_q;
    assign acc_clr_o  = acc_clr_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign step_idx_o = step_q;

endmodule

// File: tb/tb_chirp_sweep_ctrl.sv
// tb/tb_chirp_sweep_ctrl.sv - self-checking bench for chirp_sweep_ctrl
module tb_chirp_sweep_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [31:0] f_start;
    logic [31:0] f_step;
    logic [15:0] n_steps;
    logic [15:0] dwell;
    logic        triangle;
    logic        continuous;
    logic [31:0] ftw;
    logic        acc_clr;
    logic        busy;
    logic        done;
    logic [15:0] step_idx;

    int tests = 0;
    int fails = 0;

    // Expected per-cycle outputs, index 0 = first cycle after the start edge
    logic [31:0] e_ftw[$];
    logic [31:0] e_idx[$];
    logic        e_busy[$];
    logic        e_clr[$];
    logic        e_done[$];

    chirp_sweep_ctrl #(.N(32), .CNT_W(16)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .abort_i      (abort),
        .f_start_i    (f_start),
        .f_step_i     (f_step),
        .n_steps_i    (n_steps),
        .dwell_i      (dwell),
        .triangle_i   (triangle),
        .continuous_i (continuous),
        .ftw_o        (ftw),
        .acc_clr_o    (acc_clr),
        .busy_o       (busy),
        .done_o       (done),
        .step_idx_o   (step_idx)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [31:0] xf, input logic [31:0] xi,
                           input logic xb, input logic xc, input logic xd);
        chk({tag, " ftw"}, ftw, xf);
        chk({tag, " step_idx"}, {16'd0, step_idx}, xi);
        chk({tag, " busy"}, {31'd0, busy}, {31'd0, xb});
        chk({tag, " acc_clr"}, {31'd0, acc_clr}, {31'd0, xc});
        chk({tag, " done"}, {31'd0, done}, {31'd0, xd});
    endtask

    // Sweep reference: step k of a ramp plays f_start + k*f_step for dwell+1 cycles
    task automatic build(input logic [31:0] fs, input logic [31:0] fst, input int n, input int d,
                         input bit tri_m, input bit cont, input int periods);
        e_ftw.delete(); e_idx.delete(); e_busy.delete(); e_clr.delete(); e_done.delete();
        for (int p = 0; p < periods; p++) begin
            for (int k = 0; k <= n; k++) begin
                for (int c = 0; c <= d; c++) begin
                    e_ftw.push_back(fs + fst * k);
                    e_idx.push_back(k);
                    e_busy.push_back(1'b1);
                    e_clr.push_back(p == 0 && k == 0 && c == 0);
                    e_done.push_back(p > 0 && k == 0 && c == 0);
                end
            end
            if (tri_m && n > 0) begin
                for (int k = n - 1; k >= 0; k--) begin
                    for (int c = 0; c <= d; c++) begin
                        e_ftw.push_back(fs + fst * k);
                        e_idx.push_back(k);
                        e_busy.push_back(1'b1);
                        e_clr.push_back(1'b0);
                        e_done.push_back(1'b0);
                    end
                end
            end
        end
        if (!cont) begin
            e_ftw.push_back(32'd0);
            e_idx.push_back(32'd0);
            e_busy.push_back(1'b0);
            e_clr.push_back(1'b0);
            e_done.push_back(1'b1);
        end
    endtask

    // Called at a negedge with the DUT idle; abort_at < 0 means run to completion
    task automatic run(input string name, input logic [31:0] fs, input logic [31:0] fst,
                       input int n, input int d, input bit tri_m, input bit cont,
                       input int periods, input int abort_at);
        int len;
        build(fs, fst, n, d, tri_m, cont, periods);
        len = e_ftw.size();
        f_start = fs; f_step = fst; n_steps = 16'(n); dwell = 16'(d);
        triangle = tri_m; continuous = cont; start = 1'b1; abort = 1'b0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            chk_all($sformatf("%s c%0d", name, i), e_ftw[i], e_idx[i], e_busy[i], e_clr[i], e_done[i]);
            if (i == abort_at) begin
                abort = 1'b1;
                start = 1'b0;
                @(negedge clk);
                chk_all($sformatf("%s abort", name), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
                abort = 1'b0;
                return;
            end
            if (i < len - 1) begin
                // Noise on start/config while busy must be ignored
                start = 1'($urandom_range(0, 1));
                f_start = $urandom; f_step = $urandom;
                n_steps = 16'($urandom); dwell = 16'($urandom);
                triangle = 1'($urandom_range(0, 1)); continuous = 1'($urandom_range(0, 1));
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        int n, d, len, ab;
        bit tri_m, cont;
        logic [31:0] fs, fst;

        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        f_start = '0; f_step = '0; n_steps = '0; dwell = '0; triangle = 1'b0; continuous = 1'b0;
        repeat (2) @(negedge clk);
        chk_all("reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        chk_all("idle", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        run("single", 32'h1000, 32'h100, 3, 1, 1'b0, 1'b0, 1, -1);
        run("tri", 32'h10, 32'h10, 2, 0, 1'b1, 1'b0, 1, -1);
        build(32'hFFFFFF00, 32'h80, 2, 0, 1'b0, 1'b1, 2);
        run("wrap", 32'hFFFFFF00, 32'h80, 2, 0, 1'b0, 1'b1, 2, e_ftw.size() - 1);
        run("abort", 32'h2000, 32'h40, 5, 2, 1'b1, 1'b0, 1, 7);
        run("tone", 32'h5555, 32'h1, 0, 4, 1'b1, 1'b0, 1, -1);

        // start together with abort in IDLE stays idle
        f_start = 32'h1234; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        chk_all("start_abort", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0; abort = 1'b0;
        @(negedge clk);

        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(0, 4);
            d = $urandom_range(0, 3);
            tri_m = 1'($urandom_range(0, 1));
            cont = ($urandom_range(0, 3) == 0);
            fs = $urandom; fst = $urandom;
            build(fs, fst, n, d, tri_m, cont, cont ? 2 : 1);
            len = e_ftw.size();
            if (cont) ab = len - 1;
            else if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, len - 2);
            else ab = -1;
            run($sformatf("rnd%0d", it), fs, fst, n, d, tri_m, cont, cont ? 2 : 1, ab);
        end

        // Asynchronous reset mid-dwell, between clock edges
        f_start = 32'hABCD0000; f_step = 32'h10; n_steps = 16'd4; dwell = 16'd3;
        triangle = 1'b0; continuous = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_reset busy", {31'd0, busy}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_reset", 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("post_reset c%0d", i), 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        end
        run("after_reset", 32'h300, 32'h20, 2, 1, 1'b1, 1'b0, 1, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/chirp_sweep_ctrl.md
# chirp_sweep_ctrl

Sequencer that drives the frequency tuning word of the chirp phase accumulator to produce linear frequency sweeps (LFM chirps). It latches a sweep configuration on `start`, then steps the FTW by a fixed increment at a programmable dwell rate. Supported shapes are single up-sweep, triangle (up then down), and continuous repetition. It sits between the host/config register block and the phase accumulator: `ftw` feeds the accumulator's tuning word and `acc_clr` resets its phase at chirp start.

## Interface
- `N`, 32, FTW / phase width; must match the phase accumulator.
- `CNT_W`, 16, width of the step and dwell counters.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `abort`  in  1  stop immediately; priority over everything except reset.
- `f_start`  in  N  FTW of the first step.
- `f_step`  in  N  FTW increment per step, unsigned, added modulo 2^N.
- `n_steps`  in  CNT_W  number of increments per ramp (0 = single tone).
- `dwell`  in  CNT_W  cycles per step minus 1.
- `triangle`  in  1  1 = up-ramp followed by down-ramp back to `f_start`.
- `continuous`  in  1  1 = repeat the sweep until `abort`.
- `ftw`  out  N  tuning word to the phase accumulator.
- `acc_clr`  out  1  one-cycle pulse that resets accumulator phase.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse at the end of each sweep period.
- `step_idx`  out  CNT_W  index of the current step within the current ramp.

## Operation
- States: IDLE, UP, DOWN.
- Reset values of all outputs are 0; state is IDLE.
- **IDLE**
  - `start`=1 and `abort`=0: latch `f_start`, `f_step`, `n_steps`, `dwell`, `triangle`, `continuous` into shadow registers, then go to UP.
  - On entry to UP: `ftw`=`f_start`, `step_idx`=0, dwell counter=0, `acc_clr`=1 for one cycle, `busy`=1.
  - Input changes while busy have no effect.
- **UP**
  - Dwell counter counts 0..`dwell`. When it reaches `dwell`:
    - If `step_idx`<`n_steps`: `ftw`+=`f_step` (mod 2^N), `step_idx`++, dwell counter←0.
    - If `step_idx`==`n_steps` and `triangle`=1 and `n_steps`>0: go to DOWN; `ftw`−=`f_step`, `step_idx`←`n_steps`−1.
    - Otherwise the period ends (see "End of period").
- **DOWN**
  - When the dwell counter reaches `dwell`:
    - If `step_idx`>0: `ftw`−=`f_step`, `step_idx`−−.
    - If `step_idx`==0: the period ends.
  - The peak frequency is dwelt on once, not twice.
- **End of period**
  - `done`=1 for one cycle.
  - If `continuous`=0: go to IDLE; `ftw`←0 and `busy`←0 in the same cycle.
  - If `continuous`=1: go to UP with `ftw`←`f_start` and `step_idx`←0. No `acc_clr`, so phase stays continuous.
- **abort**
  - In UP or DOWN: go to IDLE on the next edge with `ftw`←0 and `busy`←0. No `done`.
  - In IDLE: ignored.
  - `abort` and `start` together in IDLE: `start` is ignored.
- **Arithmetic**
  - Add and subtract are N-bit, wrapping modulo 2^N. No saturation.
- **Reset mid-sweep**
  - Outputs go to 0 immediately, asynchronously.
  - The next sweep requires a new `start`.

## Timing
- `start` sampled at edge t: `busy`=1, `acc_clr`=1, `ftw`=`f_start` are visible after edge t (cycle t+1).
- Step k (k=0..`n_steps`) FTW is valid for cycles t+1+k·(`dwell`+1) through t+(k+1)·(`dwell`+1).
- Single sweep length is (`n_steps`+1)·(`dwell`+1) cycles.
  - `done`=1, `busy`=0 and `ftw`=0 occur together in cycle t+1+(`n_steps`+1)·(`dwell`+1).
- Triangle sweep length is (2·`n_steps`+1)·(`dwell`+1) cycles.
- Continuous mode: the next period's `f_start` appears in the same cycle as `done`, with zero gap.
- A new `start` is accepted in the cycle `busy` returns to 0, giving a back-to-back gap of one cycle.

## Test plan
- **Single sweep:** reset, then `start` with `f_start`=0x1000, `f_step`=0x100, `n_steps`=3, `dwell`=1 → `ftw` sequence 0x1000, 0x1100, 0x1200, 0x1300, each held 2 cycles; `acc_clr` pulse on the first cycle; `done` at cycle 9 after `start`; `busy` low and `ftw`=0 with `done`.
- **Triangle:** `f_start`=0x10, `f_step`=0x10, `n_steps`=2, `dwell`=0, `triangle`=1 → `ftw` 0x10, 0x20, 0x30, 0x20, 0x10, one cycle each; `done` at cycle 6.
- **Continuous wrap:** `f_start`=0xFFFFFF00, `f_step`=0x80, `n_steps`=2, `continuous`=1 → `ftw` 0xFFFFFF00, 0xFFFFFF80, 0x00000000, then 0xFFFFFF00 again with `done` pulse; `acc_clr` only once; `busy` stays high.
- **Abort:** assert `abort` mid-ramp → next cycle `ftw`=0, `busy`=0, no `done`. Also assert `start`+`abort` together in IDLE → remains IDLE.
- **Edge config:** `n_steps`=0, `dwell`=4, `triangle`=1 → single tone `f_start` for 5 cycles, then `done`. `start` pulsed while busy → ignored; config changes mid-sweep → no effect.
- **Async reset:** deassert `rst_n` mid-dwell (between clock edges) → all outputs 0 immediately; after release, idle until next `start`.
